logicgate_checker: RTL and testbench

Synthesizable self-checking response monitor for the 4-bit `logicgate` block. It sits on the output side of the gate: it samples the `a`/`b` operands and the five gate results every clock, recomputes the expected results, and counts the samples checked and the mismatches. It also captures the first failing vector. The stimulus bench drives the gate, and this block judges it, so a run needs no waveform inspection.

---
 rtl/logicgate_checker_if.sv | 18 +
 rtl/logicgate_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_logicgate_checker.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logicgate_checker_if.sv
// Monitored bus of the 4-bit logicgate block: operands a/b and the five gate
// results y1..y5.
//   master : drives a, b, y1..y5 (the gate side / stimulus)
//   slave  : samples a, b, y1..y5 (the checker)
interface logicgate_checker_if #(
  parameter int unsigned W = 4
) ();
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [W-1:0] y4;
  logic [W-1:0] y5;

  modport master (output a, b, y1, y2, y3, y4, y5);
  modport slave  (input  a, b, y1, y2, y3, y4, y5);
endinterface

// File: rtl/logicgate_checker.sv
// Self-checking response monitor for the logicgate block. Each RUN cycle the
// gate operands and results are captured into a stage-1 register; one cycle
// later the stored results are compared against a&b, a|b, a^b, ~(a&b),
// ~(a|b). Samples and mismatching samples are counted (saturating), and the
// first failing vector of a run is optionally captured.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, stop     : begin a run (IDLE/DONE), end a run early (RUN)
//   bus (slave)     : a, b, y1..y5 under check
//   busy, done, err : RUN/DRAIN, DONE, sticky mismatch flag
//   sample_count    : samples captured this run
//   err_count       : mismatching samples this run
//   first_err_*     : index, result mask and operands of the first mismatch
//
// Build option: define CHK_FIRST_ERR_EN to build the first-error registers;
// otherwise the first_err_* outputs are tied to 0.
module logicgate_checker #(
  parameter int unsigned W           = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_SAMPLES = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  logicgate_checker_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [4:0]           first_err_mask,
  output logic [W-1:0]         first_err_a,
  output logic [W-1:0]         first_err_b
);

  localparam int unsigned     NUM_RES  = 5;
  localparam bit              LIMITED  = (NUM_SAMPLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // sample_count value just before the capture of the final sample
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(LIMITED ? (NUM_SAMPLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   capture;
  logic   clear;

  // Stage-1 sample register
  logic         s_valid;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic [W-1:0] s_y1;
  logic [W-1:0] s_y2;
  logic [W-1:0] s_y3;
  logic [W-1:0] s_y4;
  logic [W-1:0] s_y5;

  logic [NUM_RES-1:0] mask;
  logic               mismatch;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          // the stop edge ends the run without capturing
          state_next = DRAIN;
        end else begin
          capture = 1'b1;
          if (LIMITED && (sample_count == LAST_IDX)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags, registered from the next state so they track the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN) || (state_next == DRAIN);
      done <= (state_next == DONE);
    end
  end

  // Stage-1 capture; s_valid marks a sample awaiting comparison
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_a     <= '0;
      s_b     <= '0;
      s_y1    <= '0;
      s_y2    <= '0;
      s_y3    <= '0;
      s_y4    <= '0;
      s_y5    <= '0;
    end else begin
      s_valid <= capture;
      if (capture) begin
        s_a  <= bus.a;
        s_b  <= bus.b;
        s_y1 <= bus.y1;
        s_y2 <= bus.y2;
        s_y3 <= bus.y3;
        s_y4 <= bus.y4;
        s_y5 <= bus.y5;
      end
    end
  end

  // Per-result mismatch flags for the stored sample
  always_comb begin
    mask[0]  = (s_y1 != (s_a & s_b));
    mask[1]  = (s_y2 != (s_a | s_b));
    mask[2]  = (s_y3 != (s_a ^ s_b));
    mask[3]  = (s_y4 != ~(s_a & s_b));
    mask[4]  = (s_y5 != ~(s_a | s_b));
    mismatch = s_valid && (|mask);
  end

  // Saturating sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_count <= '0;
    end else if (clear) begin
      sample_count <= '0;
    end else if (capture && (sample_count != CNT_MAX)) begin
      sample_count <= sample_count + CNT_W'(1);
    end
  end

  // Saturating mismatch counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      err       <= 1'b0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

`ifdef CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] s_idx;

  // Index travels with the stage-1 sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s_idx <= '0;
    end else if (capture) begin
      s_idx <= sample_count;
    end
  end

  // First-error capture: err is still low on the first counted mismatch
  always_ff @(posedge clk) begin
    if (rst) begin
      first_err_idx  <= '0;
      first_err_mask <= '0;
      first_err_a    <= '0;
      first_err_b    <= '0;
    end else if (clear) begin
      first_err_idx  <= '0;
      first_err_mask <= '0;
      first_err_a    <= '0;
      first_err_b    <= '0;
    end else if (mismatch && !err) begin
      first_err_idx  <= s_idx;
      first_err_mask <= mask;
      first_err_a    <= s_a;
      first_err_b    <= s_b;
    end
  end
`else
  assign first_err_idx  = '0;
  assign first_err_mask = '0;
  assign first_err_a    = '0;
  assign first_err_b    = '0;
`endif

endmodule

// File: tb/tb_logicgate_checker.sv
// Bench for logicgate_checker: two instances share one gate bus, one with
// NUM_SAMPLES=50 and one unlimited (NUM_SAMPLES=0). A table of runs drives
// a gate model with optional faults; per-sample expectations are queued at
// drive time and retired when the checker's counters should reflect them.
module tb_logicgate_checker;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 16;
`ifdef CHK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic start_f = 1'b0;
  logic start_u = 1'b0;
  logic stop    = 1'b0;

  logicgate_checker_if #(.W(W)) bus ();

  logic             f_busy, f_done, f_err;
  logic [CNT_W-1:0] f_sample_count, f_err_count, f_first_idx;
  logic [4:0]       f_first_mask;
  logic [W-1:0]     f_first_a, f_first_b;
  logic             u_busy, u_done, u_err;
  logic [CNT_W-1:0] u_sample_count, u_err_count, u_first_idx;
  logic [4:0]       u_first_mask;
  logic [W-1:0]     u_first_a, u_first_b;

  logicgate_checker #(.W(W), .CNT_W(CNT_W), .NUM_SAMPLES(50)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .stop(stop), .bus(bus),
    .busy(f_busy), .done(f_done), .err(f_err),
    .sample_count(f_sample_count), .err_count(f_err_count),
    .first_err_idx(f_first_idx), .first_err_mask(f_first_mask),
    .first_err_a(f_first_a), .first_err_b(f_first_b)
  );

  logicgate_checker #(.W(W), .CNT_W(CNT_W), .NUM_SAMPLES(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .stop(stop), .bus(bus),
    .busy(u_busy), .done(u_done), .err(u_err),
    .sample_count(u_sample_count), .err_count(u_err_count),
    .first_err_idx(u_first_idx), .first_err_mask(u_first_mask),
    .first_err_a(u_first_a), .first_err_b(u_first_b)
  );

  always #5 clk = ~clk;

  // Observed outputs of the instance selected by sel
  bit               sel = 1'b0;
  logic             o_busy, o_done, o_err;
  logic [CNT_W-1:0] o_sample_count, o_err_count, o_first_idx;
  logic [4:0]       o_first_mask;
  logic [W-1:0]     o_first_a, o_first_b;

  always_comb begin
    if (sel) begin
      o_busy = u_busy; o_done = u_done; o_err = u_err;
      o_sample_count = u_sample_count; o_err_count = u_err_count;
      o_first_idx = u_first_idx; o_first_mask = u_first_mask;
      o_first_a = u_first_a; o_first_b = u_first_b;
    end else begin
      o_busy = f_busy; o_done = f_done; o_err = f_err;
      o_sample_count = f_sample_count; o_err_count = f_err_count;
      o_first_idx = f_first_idx; o_first_mask = f_first_mask;
      o_first_a = f_first_a; o_first_b = f_first_b;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard records and the reference checker state they build up
  typedef struct packed {
    logic             mism;
    logic [4:0]       mask;
    logic [CNT_W-1:0] idx;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } rec_t;

  rec_t             exp_q[$];
  int               m_err;
  logic [CNT_W-1:0] m_idx;
  logic [4:0]       m_mask;
  logic [W-1:0]     m_a, m_b;

  task automatic model_clear();
    exp_q.delete();
    m_err = 0; m_idx = '0; m_mask = '0; m_a = '0; m_b = '0;
  endtask

  // Gate model: fault 1 = y3 stuck as a&b, fault 2 = y5 bit 0 flipped on sample fidx
  task automatic drive(input int k, input bit fixed, input logic [W-1:0] fa,
                       input logic [W-1:0] fb, input int fault, input int fidx);
    logic [W-1:0] a, b, y1, y2, y3, y4, y5;
    rec_t r;
    a = fixed ? fa : W'($urandom_range(0, 15));
    b = fixed ? fb : W'($urandom_range(0, 15));
    y1 = a & b; y2 = a | b; y3 = a ^ b; y4 = ~(a & b); y5 = ~(a | b);
    if (fault == 1) y3 = a & b;
    if (fault == 2 && k == fidx) y5[0] = ~y5[0];
    bus.a = a; bus.b = b;
    bus.y1 = y1; bus.y2 = y2; bus.y3 = y3; bus.y4 = y4; bus.y5 = y5;
    r.mask = {y5 != ~(a | b), y4 != ~(a & b), y3 != (a ^ b), y2 != (a | b), y1 != (a & b)};
    r.mism = |r.mask;
    r.idx  = CNT_W'(k);
    r.a    = a;
    r.b    = b;
    exp_q.push_back(r);
  endtask

  // Retire the oldest sample: the checker's counters should now include it
  task automatic pop_check();
    rec_t r;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      return;
    end
    r = exp_q.pop_front();
    if (r.mism) begin
      if (m_err == 0) begin
        m_idx = r.idx; m_mask = r.mask; m_a = r.a; m_b = r.b;
      end
      m_err++;
    end
    chk("err_count", 32'(o_err_count), 32'(m_err));
    chk("err", 32'(o_err), 32'(m_err != 0));
  endtask

  task automatic pulse_start();
    if (sel) start_u = 1'b1; else start_f = 1'b1;
    @(negedge clk);
    start_u = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic run_case(input bit s, input int n, input bit use_stop, input bit fixed,
                          input logic [W-1:0] fa, input logic [W-1:0] fb,
                          input int fault, input int fidx);
    sel = s;
    model_clear();
    @(negedge clk);
    chk("pre_start_busy", 32'(o_busy), 32'd0);
    pulse_start();
    // one edge after start: RUN, everything cleared
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_done", 32'(o_done), 32'd0);
    chk("start_samples", 32'(o_sample_count), 32'd0);
    chk("start_errs", 32'(o_err_count), 32'd0);
    chk("start_err", 32'(o_err), 32'd0);
    chk("start_first_idx", 32'(o_first_idx), 32'd0);
    chk("start_first_mask", 32'(o_first_mask), 32'd0);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("sample_count", 32'(o_sample_count), 32'(k));
      end
      if (k >= 2) pop_check();
      drive(k, fixed, fa, fb, fault, fidx);
    end
    @(negedge clk);
    chk("final_samples", 32'(o_sample_count), 32'(n));
    pop_check();
    if (use_stop) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      pop_check();
      chk("drain_busy", 32'(o_busy), 32'd1);
      chk("drain_done", 32'(o_done), 32'd0);
      chk("drain_samples", 32'(o_sample_count), 32'(n));
    end else begin
      chk("drain_busy", 32'(o_busy), 32'd1);
      chk("drain_done", 32'(o_done), 32'd0);
      @(negedge clk);
      pop_check();
    end
    if (!use_stop) chk("done_at_end", 32'(o_done), 32'd1);
    else begin
      @(negedge clk);
      chk("done_at_end", 32'(o_done), 32'd1);
    end
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("first_idx", 32'(o_first_idx), FE ? 32'(m_idx) : 32'd0);
    chk("first_mask", 32'(o_first_mask), FE ? 32'(m_mask) : 32'd0);
    chk("first_a", 32'(o_first_a), FE ? 32'(m_a) : 32'd0);
    chk("first_b", 32'(o_first_b), FE ? 32'(m_b) : 32'd0);
  endtask

  typedef struct {
    bit         s;
    int         n;
    bit         use_stop;
    bit         fixed;
    logic [3:0] fa;
    logic [3:0] fb;
    int         fault;
    int         fidx;
    int         exp_n;
    int         exp_err;
    int         exp_idx;
    logic [4:0] exp_mask;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b0, 50, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, 0, 50, 0,  0, 5'b00000};
    tbl[1] = '{1'b0, 50, 1'b0, 1'b1, 4'b1110, 4'b1000, 1, 0, 50, 50, 0, 5'b00100};
    tbl[2] = '{1'b0, 50, 1'b0, 1'b0, 4'b0000, 4'b0000, 2, 7, 50, 1,  7, 5'b10000};
    tbl[3] = '{1'b1, 20, 1'b1, 1'b1, 4'b0101, 4'b0011, 1, 0, 20, 20, 0, 5'b00100};
    tbl[4] = '{1'b1, 20, 1'b1, 1'b0, 4'b0000, 4'b0000, 0, 0, 20, 0,  0, 5'b00000};

    bus.a = '0; bus.b = '0;
    bus.y1 = '0; bus.y2 = '0; bus.y3 = '0; bus.y4 = '0; bus.y5 = '0;

    // Reset state of both instances
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_f_busy", 32'(f_busy), 32'd0);
    chk("rst_f_done", 32'(f_done), 32'd0);
    chk("rst_f_err", 32'(f_err), 32'd0);
    chk("rst_f_samples", 32'(f_sample_count), 32'd0);
    chk("rst_f_errs", 32'(f_err_count), 32'd0);
    chk("rst_u_busy", 32'(u_busy), 32'd0);
    chk("rst_u_samples", 32'(u_sample_count), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_case(tbl[i].s, tbl[i].n, tbl[i].use_stop, tbl[i].fixed, tbl[i].fa, tbl[i].fb,
               tbl[i].fault, tbl[i].fidx);
      chk($sformatf("tbl%0d_samples", i), 32'(o_sample_count), 32'(tbl[i].exp_n));
      chk($sformatf("tbl%0d_errs", i), 32'(o_err_count), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_err", i), 32'(o_err), 32'(tbl[i].exp_err != 0));
      chk($sformatf("tbl%0d_idx", i), 32'(o_first_idx), FE ? 32'(tbl[i].exp_idx) : 32'd0);
      chk($sformatf("tbl%0d_mask", i), 32'(o_first_mask), FE ? 32'(tbl[i].exp_mask) : 32'd0);
      if (tbl[i].fixed) begin
        chk($sformatf("tbl%0d_a", i), 32'(o_first_a), FE ? 32'(tbl[i].fa) : 32'd0);
        chk($sformatf("tbl%0d_b", i), 32'(o_first_b), FE ? 32'(tbl[i].fb) : 32'd0);
      end
    end

    // DONE holds its results while idle
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(o_done), 32'd1);
    chk("done_hold_samples", 32'(o_sample_count), 32'd20);

    // Reset in the middle of a faulty run
    sel = 1'b0;
    model_clear();
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      drive(k, 1'b1, 4'b1110, 4'b1000, 1, 0);
      @(negedge clk);
    end
    chk("pre_rst_samples", 32'(o_sample_count), 32'd12);
    chk("pre_rst_err", 32'(o_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_err", 32'(o_err), 32'd0);
    chk("midrst_samples", 32'(o_sample_count), 32'd0);
    chk("midrst_errs", 32'(o_err_count), 32'd0);
    chk("midrst_idx", 32'(o_first_idx), 32'd0);
    chk("midrst_mask", 32'(o_first_mask), 32'd0);
    chk("midrst_a", 32'(o_first_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_idle_busy", 32'(o_busy), 32'd0);
    chk("midrst_idle_errs", 32'(o_err_count), 32'd0);

    // Clean run after the reset
    run_case(1'b0, 50, 1'b0, 1'b0, 4'b0000, 4'b0000, 0, 0);
    chk("post_rst_samples", 32'(o_sample_count), 32'd50);
    chk("post_rst_errs", 32'(o_err_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
